// File: rtl/dctlb_pfq.sv
// dctlb_pfq: prefetch request queue feeding the dctlb prefetch port.
// Buffers line-granular prefetches and presents the head only when the core
// load port is idle. Drops L2-only requests, overwrites the oldest entry when
// full, and ages out a stale head. Every drop bumps a saturating counter.
// Request packing (pfe_req / pfetol1tlb_req): {laddr[LADDR_W-1:0], l2}.
// Optional feature: define DCTLB_PFQ_DEDUP_EN to drop accepts whose line
// address matches any valid queued entry.
module dctlb_pfq #(
    parameter int DEPTH    = 4,
    parameter int LINE_LSB = 6,
    parameter int MAX_AGE  = 63,
    parameter int CNT_W    = 16,
    parameter int LADDR_W  = 48
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         pfe_req_valid,
    output logic                         pfe_req_retry,
    input  logic [LADDR_W:0]             pfe_req,
    input  logic                         coretodctlb_ld_valid,
    input  logic                         flush,
    output logic                         pfetol1tlb_req_valid,
    input  logic                         pfetol1tlb_req_retry,
    output logic [LADDR_W:0]             pfetol1tlb_req,
    output logic [$clog2(DEPTH+1)-1:0]   pfq_occupancy,
    output logic [CNT_W-1:0]             pfq_drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);
    localparam int AGE_W = (MAX_AGE < 1) ? 1 : $clog2(MAX_AGE + 1);
    localparam logic [AGE_W-1:0] AGE_LIM  = AGE_W'(MAX_AGE);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    logic [LADDR_W-1:0] r_laddr [DEPTH];
    logic [AGE_W-1:0]   r_age   [DEPTH];
    logic [DEPTH-1:0]   r_vld;
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [OCC_W-1:0]   r_occ;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_head_vld;
    logic [LADDR_W-1:0] w_in_laddr;
    logic               w_in_l2;
    logic               w_pop;
    logic               w_expire;
    logic               w_acc;
    logic               w_dup;
    logic               w_enq;
    logic               w_full;
    logic               w_ovw;
    logic               w_adv;
    logic [1:0]         w_drops;
    logic [CNT_W:0]     w_cnt_sum;
    logic [CNT_W-1:0]   w_cnt_next;

    assign w_head_vld = r_vld[r_head];
    assign w_in_laddr = pfe_req[LADDR_W:1];
    assign w_in_l2    = pfe_req[0];

    assign pfe_req_retry        = 1'b0;
    assign pfetol1tlb_req_valid = w_head_vld && !coretodctlb_ld_valid && !flush;
    // Queued entries never carry l2=1, so the l2 field is always zero.
    assign pfetol1tlb_req       = {r_laddr[r_head], 1'b0};
    assign pfq_occupancy        = r_occ;
    assign pfq_drop_cnt         = r_cnt;

    assign w_pop    = pfetol1tlb_req_valid && !pfetol1tlb_req_retry;
    assign w_expire = (MAX_AGE != 0) && w_head_vld && (r_age[r_head] == AGE_LIM)
                      && !w_pop && !flush;
    assign w_acc    = pfe_req_valid && !flush;

`ifdef DCTLB_PFQ_DEDUP_EN
    // Line-address match against every valid entry, including a head popped this cycle.
    always_comb begin
        w_dup = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (r_vld[PTR_W'(i)] &&
                (r_laddr[i][LADDR_W-1:LINE_LSB] == w_in_laddr[LADDR_W-1:LINE_LSB]))
                w_dup = 1'b1;
        end
    end
`else
    assign w_dup = 1'b0;
`endif

    assign w_enq  = w_acc && !w_in_l2 && !w_dup;
    assign w_full = (r_occ == OCC_FULL);
    // An expiring head frees a slot just like a pop, so no overwrite is needed then.
    assign w_ovw  = w_enq && w_full && !w_pop && !w_expire;
    assign w_adv  = w_pop || w_expire || w_ovw;

    // Filter drops and overwrites are mutually exclusive; expiry can add one more.
    assign w_drops    = {1'b0, w_expire} + {1'b0, (w_acc && (w_in_l2 || w_dup)) || w_ovw};
    assign w_cnt_sum  = {1'b0, r_cnt} + (CNT_W+1)'(w_drops);
    assign w_cnt_next = w_cnt_sum[CNT_W] ? '1 : w_cnt_sum[CNT_W-1:0];

    // Queue control: pointers, valid bits and occupancy; flush behaves like reset.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_vld  <= '0;
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else begin
            // Clear the leaving head first so a same-slot write (full queue) wins.
            if (w_adv) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= r_head + 1'b1;
            end
            if (w_enq) begin
                r_vld[r_tail] <= 1'b1;
                r_tail        <= r_tail + 1'b1;
            end
            if (w_enq && !w_adv)
                r_occ <= r_occ + 1'b1;
            else if (!w_enq && w_adv)
                r_occ <= r_occ - 1'b1;
        end
    end

    // Entry payload and saturating per-entry age; age restarts on write.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (r_vld[PTR_W'(i)] && (r_age[i] != '1))
                r_age[i] <= r_age[i] + 1'b1;
        end
        if (w_enq) begin
            r_laddr[r_tail] <= w_in_laddr;
            r_age[r_tail]   <= '0;
        end
    end

    // Saturating drop counter; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset)
            r_cnt <= '0;
        else
            r_cnt <= w_cnt_next;
    end

endmodule

// File: tb/tb_dctlb_pfq.sv
// tb_dctlb_pfq: directed scenarios plus randomized traffic against a
// queue-based behavioural model of the prefetch queue.
module tb_dctlb_pfq;

    localparam int DEPTH    = 4;
    localparam int LINE_LSB = 6;
    localparam int MAX_AGE  = 5;
    localparam int CNT_W    = 4;
    localparam int LADDR_W  = 48;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;
`ifdef DCTLB_PFQ_DEDUP_EN
    localparam bit DEDUP = 1'b1;
`else
    localparam bit DEDUP = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 pfe_req_valid = 1'b0;
    logic                 pfe_req_retry;
    logic [LADDR_W:0]     pfe_req = '0;
    logic                 coretodctlb_ld_valid = 1'b0;
    logic                 flush = 1'b0;
    logic                 pfetol1tlb_req_valid;
    logic                 pfetol1tlb_req_retry = 1'b0;
    logic [LADDR_W:0]     pfetol1tlb_req;
    logic [2:0]           pfq_occupancy;
    logic [CNT_W-1:0]     pfq_drop_cnt;

    always #5 clk = ~clk;

    dctlb_pfq #(
        .DEPTH    (DEPTH),
        .LINE_LSB (LINE_LSB),
        .MAX_AGE  (MAX_AGE),
        .CNT_W    (CNT_W),
        .LADDR_W  (LADDR_W)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .pfe_req_valid        (pfe_req_valid),
        .pfe_req_retry        (pfe_req_retry),
        .pfe_req              (pfe_req),
        .coretodctlb_ld_valid (coretodctlb_ld_valid),
        .flush                (flush),
        .pfetol1tlb_req_valid (pfetol1tlb_req_valid),
        .pfetol1tlb_req_retry (pfetol1tlb_req_retry),
        .pfetol1tlb_req       (pfetol1tlb_req),
        .pfq_occupancy        (pfq_occupancy),
        .pfq_drop_cnt         (pfq_drop_cnt)
    );

    typedef struct {
        logic [LADDR_W-1:0] laddr;
        int unsigned        age;
    } ent_t;

    ent_t        q[$];
    int unsigned m_cnt = 0;
    bit          m_known = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_dup(input logic [LADDR_W-1:0] la);
        foreach (q[i])
            if ((q[i].laddr >> LINE_LSB) == (la >> LINE_LSB)) return 1'b1;
        return 1'b0;
    endfunction

    // One clock cycle: drive inputs, compare DUT against the model, advance the model.
    task automatic step(input bit rst, input bit v, input logic [LADDR_W-1:0] la,
                        input bit l2, input bit ld, input bit fl, input bit rt);
        bit   mv, pop, expire, enq;
        int   drops;
        ent_t e;
        @(negedge clk);
        reset                = rst;
        pfe_req_valid        = v;
        pfe_req              = {la, l2};
        coretodctlb_ld_valid = ld;
        flush                = fl;
        pfetol1tlb_req_retry = rt;
        #1;
        mv = (q.size() > 0) && !ld && !fl;
        if (m_known) begin
            chk("valid", 64'(pfetol1tlb_req_valid), 64'(mv));
            if (mv) begin
                chk("req_laddr", 64'(pfetol1tlb_req[LADDR_W:1]), 64'(q[0].laddr));
                chk("req_l2", 64'(pfetol1tlb_req[0]), 64'd0);
            end
            chk("occupancy", 64'(pfq_occupancy), 64'(q.size()));
            chk("drop_cnt", 64'(pfq_drop_cnt), 64'(m_cnt));
            chk("pfe_retry", 64'(pfe_req_retry), 64'd0);
        end
        if (rst || fl) begin
            q.delete();
            if (rst) begin
                m_cnt   = 0;
                m_known = 1'b1;
            end
            return;
        end
        pop    = mv && !rt;
        expire = (MAX_AGE != 0) && (q.size() > 0) && !pop && (q[0].age == MAX_AGE);
        drops  = 0;
        enq    = 1'b0;
        if (v) begin
            if (l2) drops++;
            else if (DEDUP && model_dup(la)) drops++;
            else enq = 1'b1;
        end
        if (pop || expire) void'(q.pop_front());
        if (expire) drops++;
        foreach (q[i]) q[i].age++;
        if (enq) begin
            if (q.size() == DEPTH) begin
                void'(q.pop_front());
                drops++;
            end
            e.laddr = la;
            e.age   = 0;
            q.push_back(e);
        end
        m_cnt = (m_cnt + drops > CNT_MAX) ? CNT_MAX : m_cnt + drops;
    endtask

    task automatic idle(input bit ld, input bit rt);
        step(1'b0, 1'b0, '0, 1'b0, ld, 1'b0, rt);
    endtask

    task automatic acc(input logic [LADDR_W-1:0] la, input bit l2, input bit ld, input bit rt);
        step(1'b0, 1'b1, la, l2, ld, 1'b0, rt);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset state
        do_reset();
        idle(1'b0, 1'b0);
        chk("rst_valid", 64'(pfetol1tlb_req_valid), 64'd0);
        chk("rst_occ", 64'(pfq_occupancy), 64'd0);
        chk("rst_cnt", 64'(pfq_drop_cnt), 64'd0);

        // Single accept: presentable next cycle, popped immediately
        acc(48'h1040, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        chk("t1_valid", 64'(pfetol1tlb_req_valid), 64'd1);
        chk("t1_laddr", 64'(pfetol1tlb_req[LADDR_W:1]), 64'h1040);
        idle(1'b0, 1'b0);
        chk("t1_occ_after_pop", 64'(pfq_occupancy), 64'd0);

        // Load port busy blocks presentation; then back-to-back pops
        do_reset();
        acc(48'h3000, 1'b0, 1'b1, 1'b0);
        acc(48'h5000, 1'b0, 1'b1, 1'b0);
        idle(1'b1, 1'b0);
        chk("t2_valid_blocked", 64'(pfetol1tlb_req_valid), 64'd0);
        chk("t2_occ_blocked", 64'(pfq_occupancy), 64'd2);
        idle(1'b1, 1'b0);
        idle(1'b0, 1'b0);
        chk("t2_pop1_valid", 64'(pfetol1tlb_req_valid), 64'd1);
        chk("t2_pop1_laddr", 64'(pfetol1tlb_req[LADDR_W:1]), 64'h3000);
        idle(1'b0, 1'b0);
        chk("t2_pop2_valid", 64'(pfetol1tlb_req_valid), 64'd1);
        chk("t2_pop2_laddr", 64'(pfetol1tlb_req[LADDR_W:1]), 64'h5000);
        idle(1'b0, 1'b0);
        chk("t2_occ_empty", 64'(pfq_occupancy), 64'd0);

        // Full queue overwrite of the oldest entry
        do_reset();
        for (int i = 1; i <= 5; i++) acc(48'(i) << 20, 1'b0, 1'b0, 1'b1);
        idle(1'b0, 1'b1);
        chk("t3_occ_full", 64'(pfq_occupancy), 64'd4);
        chk("t3_cnt", 64'(pfq_drop_cnt), 64'd1);
        chk("t3_head", 64'(pfetol1tlb_req[LADDR_W:1]), 64'h200000);

        // Same-line accepts
        do_reset();
        acc(48'h2000, 1'b0, 1'b0, 1'b1);
        acc(48'h2038, 1'b0, 1'b0, 1'b1);
        idle(1'b0, 1'b1);
        chk("t4_occ", 64'(pfq_occupancy), DEDUP ? 64'd1 : 64'd2);
        chk("t4_cnt", 64'(pfq_drop_cnt), DEDUP ? 64'd1 : 64'd0);

        // Aging: head held by retry expires after MAX_AGE+1 cycles
        do_reset();
        acc(48'h7000, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i <= MAX_AGE; i++) begin
            idle(1'b0, 1'b1);
            chk("t5_still_valid", 64'(pfetol1tlb_req_valid), 64'd1);
        end
        idle(1'b0, 1'b1);
        chk("t5_expired_valid", 64'(pfetol1tlb_req_valid), 64'd0);
        chk("t5_expired_occ", 64'(pfq_occupancy), 64'd0);
        chk("t5_expired_cnt", 64'(pfq_drop_cnt), 64'd1);

        // L2-only drop, then flush with three entries queued
        do_reset();
        acc(48'h9000, 1'b1, 1'b0, 1'b0);
        idle(1'b0, 1'b1);
        chk("t6_l2_occ", 64'(pfq_occupancy), 64'd0);
        chk("t6_l2_cnt", 64'(pfq_drop_cnt), 64'd1);
        acc(48'h10000, 1'b0, 1'b0, 1'b1);
        acc(48'h20000, 1'b0, 1'b0, 1'b1);
        acc(48'h30000, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 48'h40000, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("t6_flush_valid", 64'(pfetol1tlb_req_valid), 64'd0);
        chk("t6_preflush_occ", 64'(pfq_occupancy), 64'd3);
        idle(1'b0, 1'b0);
        chk("t6_flush_occ", 64'(pfq_occupancy), 64'd0);
        chk("t6_flush_cnt", 64'(pfq_drop_cnt), 64'd1);

        // Drop counter saturation
        do_reset();
        for (int i = 0; i < 20; i++) acc(48'h8000, 1'b1, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        chk("t7_cnt_sat", 64'(pfq_drop_cnt), 64'(CNT_MAX));

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            logic [LADDR_W-1:0] la;
            la = 48'h10000 + (48'($urandom_range(0, 7)) << LINE_LSB) + 48'($urandom_range(0, 63));
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 99) < 60,
                 la,
                 $urandom_range(0, 99) < 15,
                 $urandom_range(0, 99) < 30,
                 $urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < 35);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
